// File: rtl/fifo_serial_reader.sv
// Reads one byte at a time from a FIFO with registered read data and sends it
// as an 8N1 serial frame (start bit, 8 data bits LSB first, stop bit).
module fifo_serial_reader #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_re,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_PRE_LAST = CNT_W'(CLKS_PER_BIT - 2);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_START = 3'd3,
    S_DATA  = 3'd4,
    S_STOP  = 3'd5
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shift_q;
  logic             tx_q;
  logic             fifo_re_q;
  logic             busy_q;
  logic             frame_done_q;
  logic [2:0]       next_idx;

  assign next_idx = bit_idx_q + 3'd1;

  // Frame sequencer; every output is loaded alongside the state it belongs to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      tx_q         <= 1'b1;
      fifo_re_q    <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      fifo_re_q    <= 1'b0;
      frame_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (en && !fifo_empty) begin
            state_q   <= S_REQ;
            fifo_re_q <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        S_REQ: begin
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          shift_q <= fifo_data;
          cnt_q   <= '0;
          tx_q    <= 1'b0;
          state_q <= S_START;
        end
        S_START: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q     <= '0;
            bit_idx_q <= '0;
            tx_q      <= shift_q[0];
            state_q   <= S_DATA;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_DATA: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
            if (bit_idx_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= S_STOP;
            end else begin
              bit_idx_q <= next_idx;
              tx_q      <= shift_q[next_idx];
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_STOP: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            cnt_q        <= cnt_q + CNT_W'(1);
            // Registered pulse must be armed one cycle ahead of the last stop cycle.
            frame_done_q <= (cnt_q == CNT_PRE_LAST);
          end
        end
        default: begin
          state_q <= S_IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign fifo_re    = fifo_re_q;
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_fifo_serial_reader.sv
// Bench for fifo_serial_reader: directed scenarios plus random traffic, checked
// every cycle against a frame-timeline model driven by a queue-based FIFO.
module tb_fifo_serial_reader;

  localparam int C         = 4;
  localparam int FRAME_END = 10 * C + 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic       fifo_re;
  logic       tx;
  logic       busy;
  logic       frame_done;

  fifo_serial_reader #(.CLKS_PER_BIT(C)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_re    (fifo_re),
    .tx         (tx),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] fq[$];
  bit         m_active = 1'b0;
  int         m_k = 0;
  logic [7:0] m_byte = 8'h00;
  bit         re_seen = 1'b0;
  int         re_cnt = 0;
  int         fd_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  // Expected line level k cycles after the start condition was sampled.
  function automatic logic exp_tx(input int k, input logic [7:0] b);
    int j;
    if (k < 3) return 1'b1;
    j = (k - 3) / C;
    if (j == 0) return 1'b0;
    if (j == 9) return 1'b1;
    return b[j-1];
  endfunction

  task automatic tick();
    bit   was_idle;
    logic e_tx, e_re, e_busy, e_fd;
    @(posedge clk);
    was_idle = !m_active;
    if (rst) begin
      m_active = 1'b0;
    end else begin
      if (m_active) begin
        m_k++;
        if (m_k > FRAME_END) m_active = 1'b0;
      end
      if (was_idle && en && !fifo_empty && fq.size() > 0) begin
        m_active = 1'b1;
        m_k      = 1;
        m_byte   = fq[0];
      end
    end
    #1;
    if (re_seen && fq.size() > 0) fifo_data = fq.pop_front();
    else fifo_data = 8'($urandom);
    e_tx   = m_active ? exp_tx(m_k, m_byte) : 1'b1;
    e_re   = m_active && (m_k == 1);
    e_busy = m_active;
    e_fd   = m_active && (m_k == FRAME_END);
    check("tx", 32'(tx), 32'(e_tx));
    check("fifo_re", 32'(fifo_re), 32'(e_re));
    check("busy", 32'(busy), 32'(e_busy));
    check("frame_done", 32'(frame_done), 32'(e_fd));
    re_seen = fifo_re;
    if (fifo_re) re_cnt++;
    if (frame_done) fd_cnt++;
  endtask

  task automatic run(input int n, input bit rnd_empty);
    for (int i = 0; i < n; i++) begin
      if (rnd_empty && $urandom_range(1, 0) == 1) fifo_empty = 1'b1;
      else fifo_empty = (fq.size() == 0);
      tick();
    end
  endtask

  task automatic run_until_k(input int target);
    int  budget;
    bit  hit;
    budget = 300;
    hit    = m_active && (m_k == target);
    while (!hit && budget > 0) begin
      fifo_empty = (fq.size() == 0);
      tick();
      budget--;
      hit = m_active && (m_k == target);
    end
    check("reach_k", 32'(hit), 32'd1);
  endtask

  task automatic clear_counts();
    re_cnt = 0;
    fd_cnt = 0;
  endtask

  initial begin
    rst        = 1'b1;
    en         = 1'b0;
    fifo_empty = 1'b1;
    fifo_data  = 8'h00;
    tick();
    tick();
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_re", 32'(fifo_re), 32'd0);
    rst = 1'b0;

    // Single byte 0xA5
    clear_counts();
    fq.push_back(8'hA5);
    en = 1'b1;
    run(60, 1'b0);
    check("a5_re_cnt", 32'(re_cnt), 32'd1);
    check("a5_fd_cnt", 32'(fd_cnt), 32'd1);

    // Back-to-back 0x00 then 0xFF
    clear_counts();
    fq.push_back(8'h00);
    fq.push_back(8'hFF);
    run(110, 1'b0);
    check("b2b_re_cnt", 32'(re_cnt), 32'd2);
    check("b2b_fd_cnt", 32'(fd_cnt), 32'd2);
    check("b2b_idle", 32'(busy), 32'd0);

    // Held off by en=0, then released
    clear_counts();
    en = 1'b0;
    fq.push_back(8'h3C);
    run(100, 1'b0);
    check("en0_re_cnt", 32'(re_cnt), 32'd0);
    en = 1'b1;
    run(1, 1'b0);
    check("en_rise_re", 32'(fifo_re), 32'd1);
    run(50, 1'b0);

    // en dropped during data bit 3: frame completes, no further reads
    clear_counts();
    fq.push_back(8'h5A);
    fq.push_back(8'h77);
    run_until_k(3 + 4 * C);
    en = 1'b0;
    run(60, 1'b0);
    check("endrop_re_cnt", 32'(re_cnt), 32'd1);
    check("endrop_fd_cnt", 32'(fd_cnt), 32'd1);

    // Reset during data bit 5 aborts the frame; next byte goes out intact
    clear_counts();
    fq.push_back(8'h3D);
    en = 1'b1;
    run_until_k(3 + 6 * C + 1);
    rst = 1'b1;
    fifo_empty = (fq.size() == 0);
    tick();
    check("midrst_tx", 32'(tx), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    run(60, 1'b0);
    check("midrst_fd_cnt", 32'(fd_cnt), 32'd1);
    check("midrst_re_cnt", 32'(re_cnt), 32'd2);

    // Random traffic with a toggling empty flag, en and rare resets
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(3, 0) == 0 && fq.size() < 8) fq.push_back(8'($urandom));
      en  = ($urandom_range(7, 0) != 0);
      rst = ($urandom_range(299, 0) == 0);
      run(1, 1'b1);
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_serial_reader.md
FIFO_SERIAL_READER -- requirements
Module: fifo_serial_reader

Interface
REQ-001 The block SHALL have one parameter: CLKS_PER_BIT, default 16, clock cycles per serial bit, legal range 2..65535.
REQ-002 The block SHALL use a single clock and a synchronous, active-high reset.
REQ-003 Port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-004 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 Port en, input, 1 bit: permits the block to start draining a new byte.
REQ-006 Port fifo_empty, input, 1 bit: the empty flag of the FIFO being read.
REQ-007 Port fifo_data, input, 8 bits: the registered read data of the FIFO, valid one cycle after fifo_re.
REQ-008 Port fifo_re, output, 1 bit: the FIFO read enable, a single-cycle pulse per byte.
REQ-009 Port tx, output, 1 bit: the serial line, idle high.
REQ-010 Port busy, output, 1 bit: high in every state except IDLE.
REQ-011 Port frame_done, output, 1 bit: a one-cycle pulse at the end of each stop bit.

Function
REQ-012 The FSM SHALL have the states IDLE, REQ, WAIT, START, DATA and STOP, and no others.
REQ-013 In IDLE, when en=1 and fifo_empty=0 are sampled, the FSM SHALL go to REQ on the next cycle; otherwise it SHALL stay in IDLE.
REQ-014 REQ SHALL last exactly 1 cycle with fifo_re=1, then go to WAIT.
REQ-015 fifo_re SHALL be 0 in every state other than REQ.
REQ-016 WAIT SHALL last exactly 1 cycle; at its end, fifo_data SHALL be captured into an 8-bit shift register and the FSM SHALL go to START.
REQ-017 START SHALL drive tx=0 for exactly CLKS_PER_BIT cycles.
REQ-018 DATA SHALL send 8 bits LSB first, each held on tx for exactly CLKS_PER_BIT cycles, using a 3-bit index that goes from 0 to 7.
REQ-019 STOP SHALL drive tx=1 for CLKS_PER_BIT cycles; on its last cycle frame_done=1, and the FSM SHALL then go to IDLE.
REQ-020 tx SHALL be 1 in IDLE, REQ and WAIT.
REQ-021 tx SHALL be driven from a register, with no combinational glitches.
REQ-022 Latency: when the start condition is sampled at edge N, fifo_re SHALL be high in cycle N+1 and tx SHALL first go low in cycle N+3.
REQ-023 Frame length from the first start-bit cycle to the last stop-bit cycle SHALL be exactly 10*CLKS_PER_BIT cycles.
REQ-024 Back-to-back frames SHALL have at least 1 IDLE cycle between them; the gap from the end of one stop bit to the next start bit SHALL be 3 cycles when the FIFO is non-empty.
REQ-025 The bit-period counter SHALL be sized to hold CLKS_PER_BIT-1, SHALL count 0..CLKS_PER_BIT-1, and SHALL wrap to 0 at each bit boundary.
REQ-026 Once the FSM has left IDLE, changes on en or fifo_empty SHALL NOT abort or stretch the frame; the frame SHALL always complete.
REQ-027 When en=0, no new fifo_re SHALL be issued; a frame already in progress SHALL finish normally.
REQ-028 fifo_empty=1 in IDLE SHALL keep the block idle indefinitely, with no reads.
REQ-029 fifo_data SHALL be sampled only at the end of WAIT; its value in all other cycles SHALL have no effect.

Reset
REQ-030 While rst=1, the next edge SHALL set: state=IDLE, tx=1, fifo_re=0, busy=0, frame_done=0, and the counter, bit index and shift register to 0.
REQ-031 Reset SHALL take priority over all other inputs.
REQ-032 A reset asserted mid-frame SHALL abort the frame immediately: tx=1 on the next cycle, with no frame_done.
REQ-033 The byte in flight SHALL be lost, and no extra fifo_re SHALL occur because of the reset.

Verification (CLKS_PER_BIT=4)
REQ-034 Single byte: fifo_empty=0, fifo_data=0xA5, en=1 -> exactly one fifo_re pulse; tx shows 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; frame_done pulses once in cycle 40 of the frame.
REQ-035 Two bytes 0x00 then 0xFF, with fifo_empty going high after the second read -> exactly 2 fifo_re pulses, 2 correct frames, a 3-cycle gap between them, then the block idles with busy=0.
REQ-036 en=0 with fifo_empty=0 for 100 cycles -> fifo_re stays 0 and tx stays 1; en then rises -> fifo_re is high 1 cycle later.
REQ-037 en dropped during DATA bit 3 -> the frame completes all 10 bits, and no further fifo_re is issued.
REQ-038 rst pulsed during DATA bit 5 -> tx=1 and busy=0 on the next cycle, with no frame_done; the next byte is sent as a complete, correct frame.
REQ-039 fifo_empty toggling every cycle in IDLE -> fifo_re is never asserted in a cycle following a sampled fifo_empty=1, and every fifo_re is a single-cycle pulse.
